// File: rtl/image_packet_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : image_packet_sequencer
// Brief   : Buffers spike packets and replays them as row strobes with image
//           framing; ORs the core's spike outputs over each image.
// Revision: 1.0 - initial release
// ============================================================================
module image_packet_sequencer #(
  parameter int FIFO_DEPTH    = 16,
  parameter int AXON_BITS     = 8,
  parameter int NUM_NEURONS   = 256,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   pkt_valid_i,
  output logic                   pkt_ready_o,
  input  logic [AXON_BITS-1:0]   pkt_axon_i,
  input  logic                   pkt_last_i,
  output logic [AXON_BITS-1:0]   axon_idx_o,
  output logic                   axon_en_o,
  output logic                   new_image_packet_o,
  output logic                   last_image_packet_o,
  input  logic [NUM_NEURONS-1:0] spike_i,
  output logic [NUM_NEURONS-1:0] spike_vec_o,
  output logic                   image_done_o,
  output logic [15:0]            pkt_count_o,
  output logic                   busy_o
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_PTR_W:0]   c_DEPTH_CNT   = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [c_SET_W-1:0] c_SETTLE_LAST = c_SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEW    = 3'd1,
    S_ISSUE  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [AXON_BITS:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;
  logic [c_SET_W-1:0]   r_settle_cnt;
  logic                 r_last_lat;
  logic [AXON_BITS:0]   w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_settle_end;

  assign w_full       = (r_count == c_DEPTH_CNT);
  assign w_empty      = (r_count == '0);
  assign w_push       = pkt_valid_i & ~w_full;
  assign w_pop        = (r_state == S_ISSUE) & ~w_empty;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_settle_end = (r_state == S_SETTLE) && (r_settle_cnt == c_SETTLE_LAST);
  assign pkt_ready_o  = ~w_full;
  assign busy_o       = (r_state != S_IDLE);

  // Storage is not reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {pkt_last_i, pkt_axon_i};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (!w_empty) w_next_state = S_NEW;
      S_NEW:    w_next_state = S_ISSUE;
      S_ISSUE:  if (!w_empty) w_next_state = S_SETTLE;
      S_SETTLE: if (w_settle_end) w_next_state = r_last_lat ? S_DONE : S_ISSUE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Outputs are registered, so every strobe appears one cycle after its state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_settle_cnt        <= '0;
      r_last_lat          <= 1'b0;
      axon_idx_o          <= '0;
      axon_en_o           <= 1'b0;
      new_image_packet_o  <= 1'b0;
      last_image_packet_o <= 1'b0;
      image_done_o        <= 1'b0;
      spike_vec_o         <= '0;
      pkt_count_o         <= '0;
    end else begin
      axon_en_o           <= w_pop;
      last_image_packet_o <= w_pop & w_head[AXON_BITS];
      new_image_packet_o  <= (r_state == S_NEW);
      image_done_o        <= (r_state == S_DONE);
      r_settle_cnt        <= (r_state == S_SETTLE) ? r_settle_cnt + c_SET_W'(1) : '0;
      if (w_pop) begin
        axon_idx_o <= w_head[AXON_BITS-1:0];
        r_last_lat <= w_head[AXON_BITS];
      end
      if (r_state == S_NEW) begin
        spike_vec_o <= '0;
        pkt_count_o <= '0;
      end else begin
        if (w_settle_end) spike_vec_o <= spike_vec_o | spike_i;
        if (w_pop && pkt_count_o != 16'hFFFF) pkt_count_o <= pkt_count_o + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_packet_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_image_packet_sequencer
// Brief   : Scoreboard bench for image_packet_sequencer (framing, order, spikes).
// Revision: 1.0 - initial release
// ============================================================================
module tb_image_packet_sequencer;
  localparam int FIFO_DEPTH    = 16;
  localparam int AXON_BITS     = 8;
  localparam int NUM_NEURONS   = 256;
  localparam int SETTLE_CYCLES = 1;

  logic                   wb_clk_i = 1'b0;
  logic                   wb_rst_i = 1'b0;
  logic                   pkt_valid_i = 1'b0;
  logic                   pkt_ready_o;
  logic [AXON_BITS-1:0]   pkt_axon_i = '0;
  logic                   pkt_last_i = 1'b0;
  logic [AXON_BITS-1:0]   axon_idx_o;
  logic                   axon_en_o;
  logic                   new_image_packet_o;
  logic                   last_image_packet_o;
  logic [NUM_NEURONS-1:0] spike_i = '0;
  logic [NUM_NEURONS-1:0] spike_vec_o;
  logic                   image_done_o;
  logic [15:0]            pkt_count_o;
  logic                   busy_o;

  image_packet_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH), .AXON_BITS(AXON_BITS),
    .NUM_NEURONS(NUM_NEURONS), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .pkt_axon_i(pkt_axon_i), .pkt_last_i(pkt_last_i),
    .axon_idx_o(axon_idx_o), .axon_en_o(axon_en_o),
    .new_image_packet_o(new_image_packet_o), .last_image_packet_o(last_image_packet_o),
    .spike_i(spike_i), .spike_vec_o(spike_vec_o), .image_done_o(image_done_o),
    .pkt_count_o(pkt_count_o), .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [AXON_BITS:0] exp_q [$];
  int strobe_cyc [$];
  int new_cyc [$];
  int done_cyc [$];
  logic [NUM_NEURONS-1:0] done_vec = '0;
  int done_cnt = 0;
  int img_cnt = 0;
  int n_pushed = 0;
  int n_popped = 0;
  bit prev_en = 1'b0;
  bit saw_full = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Holds valid until accepted; the expected entry is queued for the edge that takes it.
  task automatic push_pkt(input logic [AXON_BITS-1:0] axon, input logic last, output int t_edge);
    int waited = 0;
    @(negedge wb_clk_i);
    pkt_valid_i = 1'b1;
    pkt_axon_i  = axon;
    pkt_last_i  = last;
    while (!pkt_ready_o && waited < 200) begin
      @(negedge wb_clk_i);
      waited++;
    end
    if (!pkt_ready_o) check("push_timeout", 0, 1);
    else exp_q.push_back({last, axon});
    @(posedge wb_clk_i);
    n_pushed++;
    #1;
    t_edge      = cyc;
    pkt_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int i = 0;
    while (done_cyc.size() < target && i < budget) begin
      @(negedge wb_clk_i);
      i++;
    end
    #1;
    check("done_timeout", 256'(done_cyc.size() >= target), 1);
  endtask

  // Output monitor: scoreboard pops on each strobe and framing invariants.
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      if (new_image_packet_o) begin
        new_cyc.push_back(cyc);
        check("new_clr_vec", spike_vec_o, '0);
        check("new_clr_cnt", pkt_count_o, 0);
        img_cnt = 0;
      end
      if (axon_en_o) begin
        strobe_cyc.push_back(cyc);
        n_popped++;
        img_cnt++;
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else begin
          logic [AXON_BITS:0] e;
          e = exp_q.pop_front();
          check("sb_axon", axon_idx_o, e[AXON_BITS-1:0]);
          check("sb_last", last_image_packet_o, e[AXON_BITS]);
        end
        check("pkt_count", pkt_count_o, img_cnt);
      end
      if (last_image_packet_o && !axon_en_o) check("last_alone", 1, 0);
      if (axon_en_o && prev_en) check("en_pulse", 1, 0);
      prev_en = axon_en_o;
      if (image_done_o) begin
        done_cyc.push_back(cyc);
        done_vec = spike_vec_o;
        done_cnt = int'(pkt_count_o);
      end
      if (!pkt_ready_o || (n_pushed - n_popped) == FIFO_DEPTH) begin
        if (!pkt_ready_o) saw_full = 1'b1;
        check("ready_full", pkt_ready_o, 256'((n_pushed - n_popped) != FIFO_DEPTH));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, tmp, bs, bn, bd, k;
    logic [NUM_NEURONS-1:0] v_exp, v42, v200, noise;

    // Test 1: reset values, then a push attempt while in reset.
    repeat (3) @(negedge wb_clk_i);
    check("rst_ready", pkt_ready_o, 1);
    check("rst_strobes", {axon_en_o, new_image_packet_o, last_image_packet_o, image_done_o, busy_o}, 0);
    check("rst_idx_cnt", {axon_idx_o, pkt_count_o}, 0);
    check("rst_vec", spike_vec_o, '0);
    wb_rst_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    bn = new_cyc.size();
    wb_rst_i = 1'b0;
    pkt_valid_i = 1'b1; pkt_axon_i = 8'd77; pkt_last_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    check("rst_ready_valid", pkt_ready_o, 1);
    pkt_valid_i = 1'b0;
    wb_rst_i = 1'b1;
    repeat (8) @(negedge wb_clk_i);
    check("rst_no_push_busy", busy_o, 0);
    check("rst_no_push_new", new_cyc.size(), bn);

    // Test 2: single image 5,17,255 with cycle-exact framing.
    bs = strobe_cyc.size(); bn = new_cyc.size(); bd = done_cyc.size();
    push_pkt(8'd5, 1'b0, t0);
    push_pkt(8'd17, 1'b0, tmp);
    push_pkt(8'd255, 1'b1, tmp);
    wait_done(bd + 1, 40);
    check("t2_new_cyc", q_at(new_cyc, bn), t0 + 2);
    check("t2_strobe0", q_at(strobe_cyc, bs), t0 + 3);
    check("t2_strobe1", q_at(strobe_cyc, bs + 1), t0 + 3 + (1 + SETTLE_CYCLES));
    check("t2_strobe2", q_at(strobe_cyc, bs + 2), t0 + 3 + 2 * (1 + SETTLE_CYCLES));
    check("t2_done_cyc", q_at(done_cyc, bd), q_at(strobe_cyc, bs + 2) + SETTLE_CYCLES + 1);
    check("t2_count", done_cnt, 3);
    repeat (3) @(negedge wb_clk_i);

    // Test 3: continuous push; issue interleaves, so more than 20 are needed to fill 16 entries.
    bd = done_cyc.size();
    for (int i = 0; i < 36; i++) push_pkt(8'((i * 7 + 3) % 256), 1'(i == 35), tmp);
    wait_done(bd + 1, 200);
    check("t3_saw_full", saw_full, 1);
    check("t3_q_empty", exp_q.size(), 0);
    check("t3_count", done_cnt, 36);
    repeat (3) @(negedge wb_clk_i);

    // Test 4: spikes only count on each packet's sample cycle.
    v42 = '0; v42[42] = 1'b1;
    v200 = '0; v200[200] = 1'b1;
    noise = '0; noise[7] = 1'b1;
    v_exp = v42 | v200;
    bd = done_cyc.size();
    k = 0;
    fork
      begin
        push_pkt(8'd10, 1'b0, tmp);
        push_pkt(8'd11, 1'b0, tmp);
        push_pkt(8'd12, 1'b1, tmp);
      end
      begin
        for (int i = 0; i < 40 && k < 3; i++) begin
          @(negedge wb_clk_i);
          if (axon_en_o) begin
            k++;
            spike_i = (k == 1) ? v42 : (k == 3) ? v200 : '0;
          end else spike_i = noise;
        end
        @(negedge wb_clk_i);
        spike_i = '0;
      end
    join
    wait_done(bd + 1, 40);
    check("t4_spike_vec", done_vec, v_exp);
    repeat (3) @(negedge wb_clk_i);

    // Test 5: reset after two of four packets issued.
    bs = strobe_cyc.size(); bn = new_cyc.size(); bd = done_cyc.size();
    fork
      begin
        push_pkt(8'd20, 1'b0, tmp);
        push_pkt(8'd21, 1'b0, tmp);
        push_pkt(8'd22, 1'b0, tmp);
        push_pkt(8'd23, 1'b1, tmp);
      end
      begin
        for (int i = 0; i < 40 && strobe_cyc.size() < bs + 2; i++) @(negedge wb_clk_i);
      end
    join
    check("t5_two_issued", strobe_cyc.size(), bs + 2);
    #2;
    wb_rst_i = 1'b0;
    #1;
    check("t5_rst_strobes", {axon_en_o, new_image_packet_o, image_done_o, busy_o}, 0);
    check("t5_rst_ready", pkt_ready_o, 1);
    check("t5_rst_cnt", pkt_count_o, 0);
    check("t5_rst_vec", spike_vec_o, '0);
    exp_q.delete();
    n_pushed = n_popped;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    repeat (8) @(negedge wb_clk_i);
    check("t5_no_done", done_cyc.size(), bd);
    check("t5_fifo_flushed", new_cyc.size(), bn + 1);
    push_pkt(8'd99, 1'b1, tmp);
    wait_done(bd + 1, 40);
    check("t5_new_after", new_cyc.size(), bn + 2);
    repeat (3) @(negedge wb_clk_i);

    // Test 6: two 2-packet images queued together.
    bs = strobe_cyc.size(); bn = new_cyc.size(); bd = done_cyc.size();
    push_pkt(8'd30, 1'b0, tmp);
    push_pkt(8'd31, 1'b1, tmp);
    push_pkt(8'd40, 1'b0, tmp);
    push_pkt(8'd41, 1'b1, tmp);
    wait_done(bd + 2, 80);
    check("t6_new_pulses", new_cyc.size(), bn + 2);
    check("t6_done_pulses", done_cyc.size(), bd + 2);
    check("t6_gap", q_at(strobe_cyc, bs + 2) - q_at(strobe_cyc, bs + 1), SETTLE_CYCLES + 4);
    check("t6_count", done_cnt, 2);
    check("t6_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
